// File: rtl/fpu_mult_dispatch.sv
// fpu_mult_dispatch: valid/ready front-end that issues one operand pair at a time to the FSM_Mult_Function multiply core.
// Latency: beg_FSM_o 1 cycle after accept; out_valid_o 1 cycle after core_ready_i is sampled in WAIT.
// Backpressure: in_ready_o low while an operation is in flight; the result is held in HOLD until out_ready_i.
// Optional WAIT watchdog (timeout result, core abort pulse) is built when FPU_MULT_WATCHDOG_EN is defined.
module fpu_mult_dispatch #(
  parameter int W              = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     op_a_i,
  input  logic [W-1:0]     op_b_i,
  output logic [W-1:0]     Data_X_o,
  output logic [W-1:0]     Data_Y_o,
  output logic             beg_FSM_o,
  output logic             ack_FSM_o,
  input  logic             core_ready_i,
  input  logic [W-1:0]     core_result_i,
  input  logic             core_ovf_i,
  input  logic             core_unf_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     result_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             err_timeout_o,
  output logic             core_abort_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] ops_done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     data_x_q, data_x_d;
  logic [W-1:0]     data_y_q, data_y_d;
  logic [W-1:0]     result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CNT_W-1:0] ops_q, ops_d;

`ifdef FPU_MULT_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic             wd_expire;

  // wd_q holds the WAIT cycles already spent, so this cycle is number wd_q+1
  assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and datapath capture; every register holds unless its state says otherwise
  always_comb begin
    state_d  = state_q;
    data_x_d = data_x_q;
    data_y_d = data_y_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ops_d    = ops_q;
`ifdef FPU_MULT_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
    abort_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          data_x_d = op_a_i;
          data_y_d = op_b_i;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FPU_MULT_WATCHDOG_EN
        wd_d    = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A ready core always beats a watchdog expiry in the same cycle
        if (core_ready_i) begin
          result_d = core_result_i;
          ovf_d    = core_ovf_i;
          unf_d    = core_unf_i;
`ifdef FPU_MULT_WATCHDOG_EN
          err_d    = 1'b0;
`endif
          state_d  = S_HOLD;
        end
`ifdef FPU_MULT_WATCHDOG_EN
        else if (wd_expire) begin
          result_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          err_d    = 1'b1;
          abort_d  = 1'b1;
          state_d  = S_HOLD;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_HOLD: begin
        if (out_ready_i) begin
          ops_d   = ops_q + CNT_W'(1);
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_x_q <= '0;
      data_y_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_x_q <= data_x_d;
      data_y_q <= data_y_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ops_q    <= ops_d;
    end
  end

`ifdef FPU_MULT_WATCHDOG_EN
  // Watchdog count, timeout flag and the one-cycle abort request to the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q    <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign err_timeout_o = err_q;
  assign core_abort_o  = abort_q;
`else
  assign err_timeout_o = 1'b0;
  assign core_abort_o  = 1'b0;
`endif

  // Handshake outputs decode state only, so no input reaches an output combinationally
  assign in_ready_o  = (state_q == S_IDLE);
  assign beg_FSM_o   = (state_q == S_ISSUE);
  assign out_valid_o = (state_q == S_HOLD);
  assign ack_FSM_o   = (state_q == S_ACK);
  assign busy_o      = (state_q != S_IDLE);

  assign Data_X_o   = data_x_q;
  assign Data_Y_o   = data_y_q;
  assign result_o   = result_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;
  assign ops_done_o = ops_q;

endmodule

// File: tb/tb_fpu_mult_dispatch.sv
// tb_fpu_mult_dispatch: directed plus randomized checks of the multiply dispatcher against a stub core.
// Inputs are driven and outputs sampled on the falling clock edge.
// A small model tracks expected completions (mod 2^CNT_W) and begin pulses.
module tb_fpu_mult_dispatch;
  localparam int W     = 32;
  localparam int CNT_W = 4;
`ifdef FPU_MULT_WATCHDOG_EN
  localparam int TO      = 8;
  localparam int LAT_DIR = 6;
  localparam int LAT_MAX = 6;
`else
  localparam int TO      = 255;
  localparam int LAT_DIR = 20;
  localparam int LAT_MAX = 20;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [W-1:0]     op_a_i, op_b_i;
  logic [W-1:0]     Data_X_o, Data_Y_o;
  logic             beg_FSM_o, ack_FSM_o;
  logic             core_ready_i;
  logic [W-1:0]     core_result_i;
  logic             core_ovf_i, core_unf_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [W-1:0]     result_o;
  logic             ovf_o, unf_o;
  logic             err_timeout_o, core_abort_o, busy_o;
  logic [CNT_W-1:0] ops_done_o;

  fpu_mult_dispatch #(.W(W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .Data_X_o(Data_X_o), .Data_Y_o(Data_Y_o),
    .beg_FSM_o(beg_FSM_o), .ack_FSM_o(ack_FSM_o),
    .core_ready_i(core_ready_i), .core_result_i(core_result_i),
    .core_ovf_i(core_ovf_i), .core_unf_i(core_unf_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .ovf_o(ovf_o), .unf_o(unf_o),
    .err_timeout_o(err_timeout_o), .core_abort_o(core_abort_o),
    .busy_o(busy_o), .ops_done_o(ops_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_ops = 0;
  int exp_begs = 0;
  int beg_cnt = 0;
  int abort_cnt = 0;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (beg_FSM_o === 1'b1) beg_cnt <= beg_cnt + 1;
    if (core_abort_o === 1'b1) abort_cnt <= abort_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ops_exp();
    return 64'(exp_ops % (1 << CNT_W));
  endfunction

  // One full operation: entered and left on a falling edge with the DUT idle
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                       input logic [W-1:0] res, input logic ovf, input logic unf,
                       input int bp, input bit keep_valid,
                       input logic [W-1:0] na, input logic [W-1:0] nb);
    chk("idle_in_ready", 64'(in_ready_o), 64'(1));
    in_valid_i  = 1'b1;
    op_a_i      = a;
    op_b_i      = b;
    out_ready_i = (bp == 0);
    @(negedge clk);
    exp_begs++;
    if (keep_valid) begin
      op_a_i = na;
      op_b_i = nb;
    end else begin
      in_valid_i = 1'b0;
    end
    chk("issue_beg", 64'(beg_FSM_o), 64'(1));
    chk("issue_data_x", 64'(Data_X_o), 64'(a));
    chk("issue_data_y", 64'(Data_Y_o), 64'(b));
    chk("issue_in_ready", 64'(in_ready_o), 64'(0));
    chk("issue_busy", 64'(busy_o), 64'(1));
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait_valid", 64'(out_valid_o), 64'(0));
      chk("wait_beg", 64'(beg_FSM_o), 64'(0));
    end
    core_ready_i  = 1'b1;
    core_result_i = res;
    core_ovf_i    = ovf;
    core_unf_i    = unf;
    @(negedge clk);
    chk("hold_valid", 64'(out_valid_o), 64'(1));
    chk("hold_result", 64'(result_o), 64'(res));
    chk("hold_ovf", 64'(ovf_o), 64'(ovf));
    chk("hold_unf", 64'(unf_o), 64'(unf));
    chk("hold_err", 64'(err_timeout_o), 64'(0));
    chk("hold_data_x", 64'(Data_X_o), 64'(a));
    chk("hold_in_ready", 64'(in_ready_o), 64'(0));
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_valid", 64'(out_valid_o), 64'(1));
        chk("bp_result", 64'(result_o), 64'(res));
        chk("bp_ack", 64'(ack_FSM_o), 64'(0));
        chk("bp_in_ready", 64'(in_ready_o), 64'(0));
      end
      out_ready_i = 1'b1;
    end
    @(negedge clk);
    exp_ops++;
    chk("ack_pulse", 64'(ack_FSM_o), 64'(1));
    chk("ack_valid", 64'(out_valid_o), 64'(0));
    chk("ack_in_ready", 64'(in_ready_o), 64'(0));
    chk("ops_done", 64'(ops_done_o), ops_exp());
    out_ready_i  = 1'b0;
    core_ready_i = 1'b0;
    @(negedge clk);
    chk("post_ack", 64'(ack_FSM_o), 64'(0));
    chk("post_in_ready", 64'(in_ready_o), 64'(1));
    chk("beg_count", 64'(beg_cnt), 64'(exp_begs));
  endtask

  initial begin
    logic [W-1:0] cur_a, cur_b, nxt_a, nxt_b, rres;
    bit           kv;
    int           seen, cycles;

    rst_n = 1'b0;
    in_valid_i = 1'b0; op_a_i = '0; op_b_i = '0;
    core_ready_i = 1'b0; core_result_i = '0; core_ovf_i = 1'b0; core_unf_i = 1'b0;
    out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_x", 64'(Data_X_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));
    chk("rst_ops", 64'(ops_done_o), 64'(0));
    chk("rst_valid", 64'(out_valid_o), 64'(0));
    chk("rst_beg", 64'(beg_FSM_o), 64'(0));
    chk("rst_ack", 64'(ack_FSM_o), 64'(0));
    chk("rst_err", 64'(err_timeout_o), 64'(0));
    chk("rst_abort", 64'(core_abort_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready_o), 64'(1));

    // 1.5 x 2.0 = 3.0
    do_op(32'h3FC00000, 32'h40000000, LAT_DIR, 32'h40400000, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    // Result held under 10 cycles of backpressure
    do_op(32'h40400000, 32'h3F800000, 5, 32'h40400000, 1'b0, 1'b0, 10, 1'b0, '0, '0);
    // Overflow flag, then cleared by the next operation
    do_op(32'h7F000000, 32'h7F000000, 4, 32'h7F800000, 1'b1, 1'b0, 0, 1'b0, '0, '0);
    do_op(32'h3F800000, 32'h3F800000, 3, 32'h3F800000, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    // Back-to-back with in_valid held: second pair waits for the IDLE after ACK
    do_op(32'h11111111, 32'h22222222, 3, 32'hAAAA0001, 1'b0, 1'b1, 2, 1'b1, 32'h33333333, 32'h44444444);
    do_op(32'h33333333, 32'h44444444, 2, 32'hAAAA0002, 1'b0, 1'b0, 0, 1'b0, '0, '0);

    // Reset during WAIT discards the operation; a late core ready is ignored
    in_valid_i = 1'b1; op_a_i = 32'h12345678; op_b_i = 32'h9ABCDEF0;
    @(negedge clk);
    exp_begs++;
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_data_x", 64'(Data_X_o), 64'(0));
    chk("mid_rst_ops", 64'(ops_done_o), 64'(0));
    chk("mid_rst_result", 64'(result_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready_o), 64'(1));
    core_ready_i = 1'b1; core_result_i = 32'hDEADBEEF;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid_o !== 1'b0 || beg_FSM_o !== 1'b0) seen++;
    end
    chk("late_ready_ignored", 64'(seen), 64'(0));
    core_ready_i = 1'b0;
    chk("late_ready_result", 64'(result_o), 64'(0));

    // Core that never answers
    in_valid_i = 1'b1; op_a_i = 32'h3F800000; op_b_i = 32'h40000000;
    @(negedge clk);
    exp_begs++;
    in_valid_i = 1'b0;
`ifdef FPU_MULT_WATCHDOG_EN
    cycles = 0;
    while (out_valid_o !== 1'b1 && cycles < TO + 10) begin
      @(negedge clk);
      cycles++;
    end
    chk("wd_fire_cycles", 64'(cycles), 64'(TO + 1));
    chk("wd_err", 64'(err_timeout_o), 64'(1));
    chk("wd_result", 64'(result_o), 64'(0));
    chk("wd_ovf", 64'(ovf_o), 64'(0));
    out_ready_i = 1'b1;
    @(negedge clk);
    exp_ops++;
    chk("wd_ack", 64'(ack_FSM_o), 64'(1));
    out_ready_i = 1'b0;
    @(negedge clk);
    chk("wd_abort_once", 64'(abort_cnt), 64'(1));
    chk("wd_idle", 64'(in_ready_o), 64'(1));
`else
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (out_valid_o !== 1'b0) seen++;
    end
    chk("no_wd_valid", 64'(seen), 64'(0));
    chk("no_wd_busy", 64'(busy_o), 64'(1));
    chk("no_wd_abort", 64'(abort_cnt), 64'(0));
    chk("no_wd_err", 64'(err_timeout_o), 64'(0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    @(negedge clk);
`endif

    // Randomized operations; 20 completions wrap the 4-bit counter
    nxt_a = $urandom; nxt_b = $urandom;
    for (int n = 0; n < 20; n++) begin
      cur_a = nxt_a; cur_b = nxt_b;
      nxt_a = $urandom; nxt_b = $urandom;
      rres  = $urandom;
      kv    = (n == 19) ? 1'b0 : 1'($urandom_range(0, 1));
      do_op(cur_a, cur_b, $urandom_range(1, LAT_MAX), rres, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 4), kv, nxt_a, nxt_b);
    end
    chk("final_err", 64'(err_timeout_o), 64'(0));
    chk("final_ops", 64'(ops_done_o), ops_exp());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running required done");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fpu_mult_dispatch.md
Name: fpu_mult_dispatch

Overview:
- Upstream front-end for the multiply core controlled by FSM_Mult_Function.
- Accepts operand pairs from the FPU issue path with a valid/ready handshake and registers them.
- Drives the core's begin/ack handshake, captures the core's result and exception flags, and presents them downstream with a valid/ready handshake.
- Serialises operations: at most one operation is in flight.

Parameters:
- W, 32, operand/result width (32 single, 64 double).
- CNT_W, 16, width of the completed-operation counter.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT. Used only with the optional feature. Must be ≥ 1.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept an operand pair.
- op_a_i  in  W  operand X.
- op_b_i  in  W  operand Y.
- Data_X_o  out  W  registered operand X to the core.
- Data_Y_o  out  W  registered operand Y to the core.
- beg_FSM_o  out  1  begin pulse to the core.
- ack_FSM_o  out  1  acknowledge pulse to the core.
- core_ready_i  in  1  core ready flag.
- core_result_i  in  W  core final result.
- core_ovf_i  in  1  core exponent overflow flag.
- core_unf_i  in  1  core exponent underflow flag.
- out_valid_o  out  1  result valid downstream.
- out_ready_i  in  1  downstream accepts the result.
- result_o  out  W  registered result.
- ovf_o  out  1  registered overflow flag.
- unf_o  out  1  registered underflow flag.
- err_timeout_o  out  1  watchdog fired for this result.
- core_abort_o  out  1  one-cycle reset request to the core.
- busy_o  out  1  operation in flight (state ≠ IDLE).
- ops_done_o  out  CNT_W  count of completed handshakes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All registered outputs 0: Data_X_o, Data_Y_o, result_o, ovf_o, unf_o, err_timeout_o, ops_done_o.
  - All pulses 0.
  - in_ready_o = 1 once rst_n is released.
- Reset mid-operation: returns immediately to IDLE and discards the operation. The core is reset by the shared system reset.
- States and outputs:
  - IDLE: in_ready_o = 1.
    - in_valid_i & in_ready_o: capture op_a_i/op_b_i into Data_X_o/Data_Y_o, go to ISSUE.
  - ISSUE: beg_FSM_o = 1 for exactly one cycle, clear the watchdog count, go to WAIT.
  - WAIT: beg_FSM_o = 0.
    - core_ready_i sampled 1: capture core_result_i/core_ovf_i/core_unf_i, set err_timeout_o = 0, go to HOLD.
  - HOLD: out_valid_o = 1. result_o and flags are stable while out_valid_o is high.
    - out_ready_i = 1: ops_done_o += 1 (wraps modulo 2^CNT_W), go to ACK.
  - ACK: ack_FSM_o = 1 for exactly one cycle, go to IDLE.
- Combinational outputs: in_ready_o, out_valid_o, beg_FSM_o, ack_FSM_o and busy_o are decoded from state only. No input-to-output combinational path.
- Latency: accept at cycle 0 → beg_FSM_o at cycle 1. out_valid_o rises 1 cycle after core_ready_i is first sampled high in WAIT.
- Minimum issue interval: 4 cycles plus core latency.
- in_valid_i outside IDLE is ignored (in_ready_o = 0). The operands must be held by the producer.
- core_ready_i outside WAIT is ignored. The core holds ready high through HOLD until the ack, so it is captured only once.
- out_ready_i high before out_valid_o has no effect. A result is consumed only in HOLD.
- A zero-flag early exit by the core simply shortens WAIT; no special handling is needed here.

Optional Feature:
- Macro: FPU_MULT_WATCHDOG_EN.
- Defined:
  - WAIT counts cycles.
  - If the count reaches TIMEOUT_CYCLES without core_ready_i: result_o = 0, ovf_o = unf_o = 0, err_timeout_o = 1, core_abort_o = 1 for one cycle, go to HOLD.
  - The following ACK still pulses ack_FSM_o (harmless to an idle core).
  - If core_ready_i and the timeout occur in the same cycle, core_ready_i wins.
- Not defined:
  - No counter is present; err_timeout_o and core_abort_o are tied to 0.
  - WAIT waits indefinitely.

Test Plan:
- 1.5 × 2.0: op_a = 0x3FC00000, op_b = 0x40000000, stub core with 20-cycle latency returning 0x40400000 → beg_FSM_o pulse 1 cycle after accept. out_valid_o 1 cycle after core_ready_i, with result_o = 0x40400000, ovf = unf = 0. ack_FSM_o pulses after out_ready_i. ops_done_o = 1.
- Backpressure: out_ready_i held 0 for 10 cycles → result_o stable, out_valid_o held, in_ready_o = 0, ack_FSM_o not asserted until the acceptance cycle.
- Overflow: stub returns 0x7F800000 with core_ovf_i = 1 → ovf_o = 1, unf_o = 0; the flags clear on the next operation.
- Back-to-back: in_valid_i held high with two pairs → second pair accepted only in the IDLE cycle after ACK. Exactly two beg_FSM_o pulses, ops_done_o = 2.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0, state IDLE, in_ready_o = 1. A late core_ready_i produces no out_valid_o.
- With FPU_MULT_WATCHDOG_EN and TIMEOUT_CYCLES = 8, stub never ready → out_valid_o with err_timeout_o = 1 and result_o = 0. core_abort_o pulses once. Without the macro, out_valid_o stays 0 for 1000 cycles.
